// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM duty ramp sequencer.
package pwm_pkg;

  localparam int unsigned DUTY_W       = 4;
  localparam int unsigned MAX_DUTY_DEF = 10;

  typedef logic [DUTY_W-1:0] duty_t;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  // Command payload as carried by the valid/ready channel
  typedef struct packed {
    duty_t duty;
    logic  immediate;
  } cmd_t;

  function automatic duty_t clamp_duty(input duty_t duty, input duty_t max_code);
    return (duty > max_code) ? max_code : duty;
  endfunction

  // One code toward tgt; direction is re-evaluated on every call
  function automatic duty_t step_toward(input duty_t cur, input duty_t tgt);
    if (cur < tgt) begin
      return cur + duty_t'(1);
    end else if (cur > tgt) begin
      return cur - duty_t'(1);
    end
    return cur;
  endfunction

endpackage

// File: rtl/pwm_step_timer.sv
// Loadable down-counter pacing the ramp; holds at zero until reloaded.
module pwm_step_timer #(
  parameter int unsigned TICK_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [TICK_W-1:0] load_val,
  input  logic              en,
  output logic              zero_c
);

  logic [TICK_W-1:0] count_q;

  assign zero_c = (count_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && !zero_c) begin
      count_q <= count_q - TICK_W'(1);
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty-change sequencer for the PWM channel: immediate jumps or paced ramps.
// Optional mid-ramp retargeting is enabled by defining PWM_RAMP_RETARGET_EN.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned MAX_DUTY   = MAX_DUTY_DEF,
  parameter int unsigned STEP_TICKS = 16,
  parameter int unsigned TICK_W     = 16
) (
  input  logic              SLK,
  input  logic              RST_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic              cmd_immediate,
  output logic [DUTY_W-1:0] Porcentaje,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam duty_t             MAX_CODE = DUTY_W'(MAX_DUTY);
  localparam logic [TICK_W-1:0] RELOAD   = TICK_W'(STEP_TICKS - 1);

  state_t state_q, state_d;
  duty_t  duty_q, duty_d;
  duty_t  target_q, target_d;
  logic   done_d, err_d, busy_d, ready_d;
  logic   tmr_load, tmr_zero_c;

  cmd_t   cmd_c;
  logic   accept_c;
  logic   cmd_over_c;
  duty_t  clamped_c;

  assign cmd_c      = {cmd_duty, cmd_immediate};
  assign accept_c   = cmd_valid && cmd_ready;
  assign cmd_over_c = (cmd_c.duty > MAX_CODE);
  assign clamped_c  = clamp_duty(cmd_c.duty, MAX_CODE);

  pwm_step_timer #(
    .TICK_W (TICK_W)
  ) u_step_timer (
    .clk      (SLK),
    .rst_n    (RST_N),
    .load     (tmr_load),
    .load_val (RELOAD),
    .en       (state_q == RAMP),
    .zero_c   (tmr_zero_c)
  );

  // Next-state, duty update and pulse generation
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    done_d   = 1'b0;
    err_d    = accept_c && cmd_over_c;
    tmr_load = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          target_d = clamped_c;
          if (cmd_c.immediate) begin
            duty_d = clamped_c;
            done_d = 1'b1;
          end else if (clamped_c == duty_q) begin
            done_d = 1'b1;
          end else begin
            tmr_load = 1'b1;
            state_d  = RAMP;
          end
        end
      end

      RAMP: begin
`ifdef PWM_RAMP_RETARGET_EN
        // A new target keeps the current tick phase; the old target never reports done
        if (accept_c) begin
          target_d = clamped_c;
          if (cmd_c.immediate) begin
            duty_d  = clamped_c;
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (clamped_c == duty_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
`endif
        if (state_d == RAMP && tmr_zero_c) begin
          duty_d = step_toward(duty_q, target_d);
          if (duty_d == target_d) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tmr_load = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RAMP);
`ifdef PWM_RAMP_RETARGET_EN
    ready_d = 1'b1;
`else
    ready_d = (state_d == IDLE);
`endif
  end

  // State and registered outputs
  always_ff @(posedge SLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      duty_q     <= '0;
      target_q   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cmd_ready  <= 1'b1;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      target_q   <= target_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      cmd_ready  <= ready_d;
    end
  end

  assign Porcentaje = duty_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl (default build, STEP_TICKS=4).
module tb_pwm_ramp_ctrl;

  localparam int S    = 4;
  localparam int MAXD = 10;

  logic       SLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_immediate = 1'b0;
  logic [3:0] cmd_duty = 4'd0;
  logic       cmd_ready, busy, done, err;
  logic [3:0] Porcentaje;

  pwm_ramp_ctrl #(
    .MAX_DUTY   (MAXD),
    .STEP_TICKS (S),
    .TICK_W     (16)
  ) dut (
    .SLK           (SLK),
    .RST_N         (RST_N),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_duty      (cmd_duty),
    .cmd_immediate (cmd_immediate),
    .Porcentaje    (Porcentaje),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 SLK = ~SLK;

  typedef struct {
    int duty;
    bit busy;
    bit ready;
    bit done;
    bit err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_n = 0;
  bit   acc;

  // Reference model: a ramp is a start edge, a start code and an end code
  int   m_duty = 0;
  bit   m_busy = 1'b0;
  int   r_start = 0, r_from = 0, r_to = 0;

  always @(posedge SLK) edge_n <= edge_n + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus and queue the response expected after the next edge
  task automatic drive(input bit v, input int d, input bit imm, output bit accepted);
    exp_t x;
    int   e, t, n, dd, k;
    @(negedge SLK);
    cmd_valid     = v;
    cmd_duty      = 4'(d);
    cmd_immediate = imm;
    e        = edge_n + 1;
    x.done   = 1'b0;
    x.err    = 1'b0;
    accepted = 1'b0;
    if (m_busy) begin
      dd = e - r_start;
      n  = (r_to > r_from) ? r_to - r_from : r_from - r_to;
      k  = dd / S;
      if (k > n) k = n;
      m_duty = (r_to > r_from) ? r_from + k : r_from - k;
      if (dd == n * S) begin
        m_busy = 1'b0;
        x.done = 1'b1;
      end
    end else if (v) begin
      accepted = 1'b1;
      t     = (d > MAXD) ? MAXD : d;
      x.err = (d > MAXD);
      if (imm) begin
        m_duty = t;
        x.done = 1'b1;
      end else if (t == m_duty) begin
        x.done = 1'b1;
      end else begin
        m_busy  = 1'b1;
        r_start = e;
        r_from  = m_duty;
        r_to    = t;
      end
    end
    x.duty  = m_duty;
    x.busy  = m_busy;
    x.ready = !m_busy;
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, a);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_duty"},  int'(Porcentaje), 0);
    check({tag, "_busy"},  int'(busy), 0);
    check({tag, "_ready"}, int'(cmd_ready), 1);
    check({tag, "_done"},  int'(done), 0);
    check({tag, "_err"},   int'(err), 0);
  endtask

  // Reset asserted between edges; outputs must clear without any clock edge
  task automatic async_reset();
    @(negedge SLK);
    cmd_valid = 1'b0;
    #2 RST_N = 1'b0;
    #1 check_reset_state("async_rst");
    m_duty = 0;
    m_busy = 1'b0;
    repeat (2) @(negedge SLK);
    RST_N = 1'b1;
  endtask

  // Monitor: compare every queued cycle against the DUT outputs
  initial begin
    exp_t x;
    forever begin
      @(posedge SLK);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check("duty",  int'(Porcentaje), x.duty);
        check("busy",  int'(busy),       int'(x.busy));
        check("ready", int'(cmd_ready),  int'(x.ready));
        check("done",  int'(done),       int'(x.done));
        check("err",   int'(err),        int'(x.err));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit v, imm;
    int d;
    #1 RST_N = 1'b0;
    #1 check_reset_state("por");
    repeat (2) @(negedge SLK);
    RST_N = 1'b1;
    idle(2);

    // Ramp up 0->3, down 3->1, immediate to 7, clamp 14->10
    drive(1'b1, 3, 1'b0, acc);  idle(14);
    drive(1'b1, 1, 1'b0, acc);  idle(10);
    drive(1'b1, 7, 1'b1, acc);  idle(2);
    drive(1'b1, 14, 1'b1, acc); idle(2);

    // Null command from 4
    drive(1'b1, 4, 1'b1, acc);  idle(1);
    drive(1'b1, 4, 1'b0, acc);  idle(3);

    // Back-pressure: command held during a 0->5 ramp
    drive(1'b1, 0, 1'b1, acc);
    drive(1'b1, 5, 1'b0, acc);
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) drive(1'b1, 2, 1'b0, acc);
    check("bp_accepted", int'(acc), 1);
    for (int i = 0; i < 100 && m_busy; i++) drive(1'b0, 0, 1'b0, acc);
    idle(2);

    // Mid-ramp asynchronous reset
    drive(1'b1, 8, 1'b0, acc);
    idle(5);
    async_reset();
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      v   = ($urandom_range(0, 2) != 0);
      d   = $urandom_range(0, 15);
      imm = ($urandom_range(0, 3) == 0);
      drive(v, d, imm, acc);
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 6));
    end
    for (int i = 0; i < 100 && m_busy; i++) drive(1'b0, 0, 1'b0, acc);
    idle(2);

    @(posedge SLK);
    #2;
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Sequencer in front of the existing PWM channel. It accepts duty-change commands from the SPI command layer over a valid/ready handshake.
- Drives the PWM duty input `Porcentaje` (0..10, 10 % steps). The duty moves either immediately or as a soft ramp of one step every STEP_TICKS clocks.
- Reports busy, a completion pulse and an out-of-range error.

Parameters:
- MAX_DUTY, 10, highest legal duty code; codes above it are clamped.
- STEP_TICKS, 16, clocks between successive ramp steps; legal range 1..65535.
- TICK_W, 16, width of the step-interval counter; must satisfy 2^TICK_W > STEP_TICKS.

Ports:
- SLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command this cycle.
- cmd_duty  in  4  target duty code.
- cmd_immediate  in  1  1 = jump to target, 0 = ramp.
- Porcentaje  out  4  duty code to the PWM channel, registered.
- busy  out  1  ramp in progress.
- done  out  1  one-cycle pulse when Porcentaje reaches the accepted target.
- err  out  1  one-cycle pulse when an accepted cmd_duty exceeded MAX_DUTY.

Behaviour:
- Interface: one clock (SLK); reset is asynchronous and active-low (RST_N). All state is cleared on assertion of RST_N, independent of SLK.
- Reset values:
  - Porcentaje=0, target=0, tick counter=0.
  - state=IDLE, busy=0, done=0, err=0.
  - cmd_ready=1 from the first cycle after reset release.
- Accept: a transfer occurs on a rising SLK edge where cmd_valid && cmd_ready.
- Clamping: target = min(cmd_duty, MAX_DUTY). err pulses in the cycle after accept if cmd_duty > MAX_DUTY.
- States:
  - IDLE:
    - cmd_ready=1, busy=0.
    - On accept with cmd_immediate=1: Porcentaje<=target; done pulses the next cycle; stay IDLE.
    - On accept with target==Porcentaje: done pulses the next cycle; stay IDLE.
    - Otherwise: tick counter<=STEP_TICKS-1; go to RAMP.
  - RAMP:
    - busy=1, cmd_ready=0 (but see Optional Feature).
    - Counter decrements each clock.
    - When the counter is 0, Porcentaje steps ±1 toward target.
    - If the new value equals target: go to IDLE, done pulses the same cycle busy falls.
    - Otherwise: reload the counter to STEP_TICKS-1.
- Ramp timing: a ramp of N steps takes exactly N*STEP_TICKS clocks from the accept edge to the final Porcentaje update.
- Width rules:
  - Porcentaje never leaves 0..MAX_DUTY.
  - Step direction is decided every step by comparing Porcentaje with target. No wrap-around is possible.
- Pulse rules: done and err are single-cycle; they can coincide.
- STEP_TICKS=1: one step per clock.
- Mid-ramp reset: Porcentaje returns to 0 immediately (asynchronous); the ramp is abandoned with no done pulse.
- cmd_valid held high while cmd_ready=0 is ignored. The command is taken when cmd_ready next rises.

Optional Feature:
- Macro: PWM_RAMP_RETARGET_EN.
- Defined:
  - cmd_ready=1 in RAMP as well.
  - An accept in RAMP replaces target without reloading the tick counter.
  - cmd_immediate=1 in RAMP jumps Porcentaje to the new target and returns to IDLE with done.
  - A new target equal to the current Porcentaje ends the ramp with done on the next cycle.
  - No done is emitted for the superseded target.
- Undefined: cmd_ready=0 throughout RAMP; behaviour is exactly as above.

Decomposition:
- Shared package pwm_pkg:
  - DUTY_W=4.
  - MAX_DUTY_DEF=10.
  - State enum {IDLE, RAMP}.
  - Duty code type.
- Sub-module pwm_step_timer: a loadable down-counter (load, en, zero flag) sized by TICK_W. It is instantiated once.
- Top holds the FSM, the target register and the clamp logic.

Test Plan:
- Reset: assert RST_N=0 mid-ramp between clock edges -> Porcentaje=0, busy=0, cmd_ready=1 with no clock edge; no done pulse.
- Ramp up, STEP_TICKS=4: from 0, accept duty=3 ramp -> Porcentaje becomes 1 at accept+4, 2 at +8, 3 at +12. done pulses at +12, busy falls at +12.
- Ramp down plus immediate: from 3, accept duty=1 ramp -> 2 then 1 at 4-clock spacing. Then accept duty=7 immediate -> Porcentaje=7 the next cycle with done.
- Clamp: accept duty=14 immediate -> Porcentaje=10, err and done both pulse once.
- Back-pressure: during a 0->5 ramp hold cmd_valid=1, duty=2 -> cmd_ready=0 until done. The command is accepted on the cycle after done and ramps down to 2. With PWM_RAMP_RETARGET_EN it is accepted immediately and the ramp reverses at the next tick.
- Null command: from 4, accept duty=4 ramp -> no Porcentaje change, done the next cycle, busy stays 0.
